flow_dispatcher: RTL and testbench

- Parametrised successor to the fixed 4-way flow classifier: distributes whole packets from one input stream to NUM_OUT processing-core outputs.
- Selection is round-robin over a runtime core-enable mask.
- Each transfer uses a per-output req/ack handshake, with ack timeout and skip.
- Each packet is tagged with a per-output protocol-match flag and a programmable route/bypass value.
- Sits between the input arbiter and the per-core packet buffers.

---
 rtl/flow_dispatcher.sv | 244 ++++++++++++++++++++++++
 tb/tb_flow_dispatcher.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/flow_dispatcher.sv
// Packet dispatcher: forwards whole packets from one input stream to NUM_OUT core
// outputs, round-robin over an enable mask, with req/ack handshake and ack timeout.

module flow_dispatcher_lane #(
   parameter int DW = 64,
   parameter int CW = 8,
   parameter int RW = 24
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          own_i,
   input  logic          latch_i,
   input  logic          wr_i,
   input  logic          entry_i,
   input  logic          clr_i,
   input  logic          hit_i,
   input  logic          hit_val_i,
   input  logic [DW-1:0] data_i,
   input  logic [CW-1:0] ctrl_i,
   input  logic [RW-1:0] route_i,
   input  logic          bypass_i,
   output logic [DW-1:0] data_o,
   output logic [CW-1:0] ctrl_o,
   output logic          wr_o,
   output logic          req_o,
   output logic [RW-1:0] route_o,
   output logic          bypass_o,
   output logic          proto_o
);
   logic [DW-1:0] data_q;
   logic [CW-1:0] ctrl_q;
   logic [RW-1:0] route_q;
   logic          wr_q, req_q, bypass_q, proto_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q   <= '0;
         ctrl_q   <= '0;
         route_q  <= '0;
         wr_q     <= 1'b0;
         req_q    <= 1'b0;
         bypass_q <= 1'b0;
         proto_q  <= 1'b0;
      end else begin
         wr_q <= own_i & wr_i;
         if (own_i & wr_i) begin
            data_q <= data_i;
            ctrl_q <= ctrl_i;
         end
         // Route/bypass are captured only when this lane wins selection.
         if (latch_i) begin
            route_q  <= route_i;
            bypass_q <= bypass_i;
         end
         if (latch_i)            req_q <= 1'b1;
         else if (own_i & clr_i) req_q <= 1'b0;
         if (own_i & entry_i)    proto_q <= 1'b0;
         else if (own_i & hit_i) proto_q <= hit_val_i;
      end
   end

   assign data_o   = data_q;
   assign ctrl_o   = ctrl_q;
   assign wr_o     = wr_q;
   assign req_o    = req_q;
   assign route_o  = route_q;
   assign bypass_o = bypass_q;
   assign proto_o  = proto_q;
endmodule

module flow_dispatcher #(
   parameter int         NUM_OUT     = 4,
   parameter int         DATA_WIDTH  = 64,
   parameter int         CTRL_WIDTH  = 8,
   parameter int         ROUTE_WIDTH = 24,
   parameter int         PROTO_WORD  = 3,
   parameter int         PROTO_LSB   = 0,
   parameter logic [7:0] PROTO_VALUE = 8'h11,
   parameter int         ACK_TIMEOUT = 255
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [DATA_WIDTH-1:0]          in_data,
   input  logic [CTRL_WIDTH-1:0]          in_ctrl,
   input  logic                           in_wr,
   output logic                           in_rdy,
   input  logic [NUM_OUT-1:0]             core_enable,
   input  logic [ROUTE_WIDTH-1:0]         route_value,
   input  logic                           bypass_en,
   output logic [NUM_OUT*DATA_WIDTH-1:0]  out_data,
   output logic [NUM_OUT*CTRL_WIDTH-1:0]  out_ctrl,
   output logic [NUM_OUT-1:0]             out_wr,
   output logic [NUM_OUT-1:0]             out_req,
   input  logic [NUM_OUT-1:0]             out_ack,
   output logic [NUM_OUT*ROUTE_WIDTH-1:0] out_pkt_route,
   output logic [NUM_OUT-1:0]             out_bypass,
   output logic [NUM_OUT-1:0]             out_protocol,
   output logic                           timeout_err,
   output logic [$clog2(NUM_OUT)-1:0]     cur_output
);
   localparam int SELW = $clog2(NUM_OUT);
   localparam int TW   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam int WCW  = $clog2(PROTO_WORD + 2);

   typedef enum logic [2:0] {
      S_IDLE, S_SELECT, S_REQ, S_WAIT_ACK, S_TX, S_RELEASE, S_WAIT_DEACK
   } state_t;

   state_t          state_q, state_d;
   logic [SELW-1:0] sel_q, sel_d, ptr_q, ptr_d, pick;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [WCW-1:0]  wcnt_q, wcnt_d;
   logic            seen_q, seen_d, terr_q, terr_d;
   logic            any_en, latch, tx_entry, tx_wr, req_clr, proto_hit, proto_val;

   logic [NUM_OUT-1:0][DATA_WIDTH-1:0]  lane_data;
   logic [NUM_OUT-1:0][CTRL_WIDTH-1:0]  lane_ctrl;
   logic [NUM_OUT-1:0][ROUTE_WIDTH-1:0] lane_route;

   // First enabled index strictly after ptr_q; descending scan so the nearest wins.
   always_comb begin
      pick   = '0;
      any_en = 1'b0;
      for (int k = NUM_OUT; k >= 1; k--) begin
         if (core_enable[(int'(ptr_q) + k) % NUM_OUT]) begin
            pick   = SELW'((int'(ptr_q) + k) % NUM_OUT);
            any_en = 1'b1;
         end
      end
   end

   assign tx_wr     = (state_q == S_TX) && in_wr;
   assign proto_hit = tx_wr && (wcnt_q == WCW'(PROTO_WORD));
   assign proto_val = (in_data[PROTO_LSB +: 8] == PROTO_VALUE);

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      ptr_d    = ptr_q;
      tcnt_d   = tcnt_q;
      wcnt_d   = wcnt_q;
      seen_d   = seen_q;
      terr_d   = 1'b0;
      latch    = 1'b0;
      tx_entry = 1'b0;
      req_clr  = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_SELECT;
         S_SELECT: begin
            if (any_en) begin
               sel_d   = pick;
               latch   = 1'b1;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            tcnt_d  = '0;
            state_d = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (out_ack[sel_q]) begin
               tx_entry = 1'b1;
               wcnt_d   = '0;
               seen_d   = 1'b0;
               state_d  = S_TX;
            end else if (tcnt_q == TW'(ACK_TIMEOUT - 1)) begin
               req_clr = 1'b1;
               terr_d  = 1'b1;
               ptr_d   = sel_q;
               state_d = S_SELECT;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         S_TX: begin
            if (in_wr) begin
               if (wcnt_q != WCW'(PROTO_WORD + 1)) wcnt_d = wcnt_q + 1'b1;
               // A nonzero ctrl only ends the packet once a payload word was seen.
               if (in_ctrl == '0) seen_d = 1'b1;
               else if (seen_q)   state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            req_clr = 1'b1;
            ptr_d   = sel_q;
            state_d = S_WAIT_DEACK;
         end
         S_WAIT_DEACK: if (!out_ack[sel_q]) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         sel_q   <= '0;
         ptr_q   <= SELW'(NUM_OUT - 1);
         tcnt_q  <= '0;
         wcnt_q  <= '0;
         seen_q  <= 1'b0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         tcnt_q  <= tcnt_d;
         wcnt_q  <= wcnt_d;
         seen_q  <= seen_d;
         terr_q  <= terr_d;
      end
   end

   for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
      flow_dispatcher_lane #(.DW(DATA_WIDTH), .CW(CTRL_WIDTH), .RW(ROUTE_WIDTH)) u_lane (
         .clk      (clk),
         .reset    (reset),
         .own_i    (sel_q == SELW'(i)),
         .latch_i  (latch && (pick == SELW'(i))),
         .wr_i     (tx_wr),
         .entry_i  (tx_entry),
         .clr_i    (req_clr),
         .hit_i    (proto_hit),
         .hit_val_i(proto_val),
         .data_i   (in_data),
         .ctrl_i   (in_ctrl),
         .route_i  (route_value),
         .bypass_i (bypass_en),
         .data_o   (lane_data[i]),
         .ctrl_o   (lane_ctrl[i]),
         .wr_o     (out_wr[i]),
         .req_o    (out_req[i]),
         .route_o  (lane_route[i]),
         .bypass_o (out_bypass[i]),
         .proto_o  (out_protocol[i])
      );
   end

   assign out_data      = lane_data;
   assign out_ctrl      = lane_ctrl;
   assign out_pkt_route = lane_route;
   assign in_rdy        = (state_q == S_TX);
   assign timeout_err   = terr_q;
   assign cur_output    = sel_q;
endmodule

// File: tb/tb_flow_dispatcher.sv
// Directed bench for flow_dispatcher: ordering, data path, protocol flag, route
// latching, enable masks, ack timeout and asynchronous reset mid-packet.

module tb_flow_dispatcher;
   localparam int N = 4;

   logic          clk, reset;
   logic [63:0]   in_data;
   logic [7:0]    in_ctrl;
   logic          in_wr, in_rdy;
   logic [N-1:0]  core_enable;
   logic [23:0]   route_value;
   logic          bypass_en;
   logic [N*64-1:0] out_data;
   logic [N*8-1:0]  out_ctrl;
   logic [N-1:0]  out_wr, out_req, out_ack, out_bypass, out_protocol;
   logic [N*24-1:0] out_pkt_route;
   logic          timeout_err;
   logic [1:0]    cur_output;

   int total = 0;
   int bad   = 0;
   logic [N-1:0] ack_mask = '1;
   int  acnt [N];
   logic mon_en = 1'b0;
   logic viol   = 1'b0;

   flow_dispatcher #(.NUM_OUT(N), .ACK_TIMEOUT(10)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
      .in_rdy(in_rdy), .core_enable(core_enable), .route_value(route_value),
      .bypass_en(bypass_en), .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr),
      .out_req(out_req), .out_ack(out_ack), .out_pkt_route(out_pkt_route),
      .out_bypass(out_bypass), .out_protocol(out_protocol), .timeout_err(timeout_err),
      .cur_output(cur_output)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Ack responder: acks a requesting output after ~2 cycles unless masked off.
   initial begin
      out_ack = '0;
      for (int i = 0; i < N; i++) acnt[i] = 0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (out_req[i] && ack_mask[i]) begin
               if (acnt[i] >= 2) out_ack[i] = 1'b1;
               else acnt[i]++;
            end else begin
               out_ack[i] = 1'b0;
               acnt[i]    = 0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && (out_req[0] || out_req[2] || out_wr[0] || out_wr[2])) viol = 1'b1;
      end
   end

   task automatic wait_rdy();
      int n = 0;
      while (!in_rdy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rdy_wait", 64'(in_rdy), 64'd1);
   endtask

   task automatic send_pkt(input int exp_o, input int nw, input logic [7:0] pb, input int id);
      logic [63:0] d;
      logic [7:0]  c;
      logic [3:0]  m;
      wait_rdy();
      m = 4'b0001 << exp_o;
      for (int w = 0; w < nw; w++) begin
         d = {16'hC0DE, 8'(id), 8'(w), 32'h0000_005A};
         if (w == 3) d[7:0] = pb;
         c = (w == 0 || w == nw - 1) ? 8'hFF : 8'h00;
         in_data = d; in_ctrl = c; in_wr = 1'b1;
         @(posedge clk); #1;
         chk("wr_sel", 64'(out_wr), 64'(m));
         chk("data", out_data[exp_o*64 +: 64], d);
         chk("ctrl", 64'(out_ctrl[exp_o*8 +: 8]), 64'(c));
      end
      in_wr = 1'b0;
      chk("rdy_end", 64'(in_rdy), 64'd0);
   endtask

   initial begin
      int id, r2, te, rv, wv, n;
      logic [N-1:0] rq;
      reset = 1'b0; in_data = '0; in_ctrl = '0; in_wr = 1'b0;
      core_enable = 4'hF; route_value = 24'h0; bypass_en = 1'b0;
      repeat (3) @(posedge clk); #1;
      chk("rst_req", 64'(out_req), 64'd0);
      chk("rst_wr", 64'(out_wr), 64'd0);
      chk("rst_rdy", 64'(in_rdy), 64'd0);
      chk("rst_cur", 64'(cur_output), 64'd0);
      @(negedge clk); reset = 1'b1;

      // round robin over all four outputs
      id = 0;
      for (int p = 0; p < 8; p++) begin
         send_pkt(p % 4, 6, 8'h00, id); id++;
      end

      // protocol flag and route/bypass latching
      send_pkt(0, 6, 8'h11, id); id++;
      route_value = 24'h000003; bypass_en = 1'b1;
      send_pkt(1, 6, 8'h06, id); id++;
      route_value = 24'h0000AA; bypass_en = 1'b0;
      chk("proto_a", 64'(out_protocol), 64'h1);
      chk("route1", 64'(out_pkt_route[24 +: 24]), 64'h3);
      chk("bypass1", 64'(out_bypass[1]), 64'd1);
      send_pkt(2, 6, 8'h11, id); id++;
      chk("route2", 64'(out_pkt_route[48 +: 24]), 64'hAA);
      chk("bypass2", 64'(out_bypass[2]), 64'd0);
      chk("route1_hold", 64'(out_pkt_route[24 +: 24]), 64'h3);
      repeat (20) @(posedge clk); #1;
      chk("proto_hold", 64'(out_protocol), 64'h5);
      send_pkt(3, 6, 8'h11, id); id++;
      chk("proto_b", 64'(out_protocol), 64'hD);
      send_pkt(0, 3, 8'h11, id); id++;
      chk("proto_short", 64'(out_protocol), 64'hC);

      // sparse enable mask
      core_enable = 4'b1010;
      repeat (2) @(posedge clk); #1;
      mon_en = 1'b1;
      send_pkt(1, 6, 8'h00, id); id++;
      send_pkt(3, 6, 8'h00, id); id++;
      send_pkt(1, 6, 8'h00, id); id++;
      send_pkt(3, 6, 8'h00, id); id++;
      mon_en = 1'b0;
      chk("mask_0_2_quiet", 64'(viol), 64'd0);

      // ack timeout on output 2; junk input must not be consumed
      core_enable = 4'hF; ack_mask = 4'b1011;
      send_pkt(0, 6, 8'h00, id); id++;
      send_pkt(1, 6, 8'h00, id); id++;
      in_wr = 1'b1; in_ctrl = 8'h00; in_data = 64'hDEAD_BEEF_0000_0000;
      r2 = 0; te = 0; rv = 0; wv = 0; n = 0;
      while (!out_req[3] && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (out_req[2]) r2++;
         if (timeout_err) begin te++; in_wr = 1'b0; end
         if (in_rdy) rv++;
         if (out_wr != '0) wv++;
      end
      in_wr = 1'b0;
      chk("to_req3_seen", 64'(out_req[3]), 64'd1);
      chk("to_req2_cycles", 64'(r2), 64'd11);
      chk("to_err_pulses", 64'(te), 64'd1);
      chk("to_no_rdy", 64'(rv), 64'd0);
      chk("to_no_wr", 64'(wv), 64'd0);
      ack_mask = 4'hF;
      send_pkt(3, 6, 8'h00, id); id++;

      // async reset in the middle of a packet to output 1
      send_pkt(0, 6, 8'h11, id); id++;
      wait_rdy();
      for (int w = 0; w < 3; w++) begin
         in_data = {16'hBEEF, 8'(id), 8'(w), 32'h0}; in_ctrl = (w == 0) ? 8'hFF : 8'h00;
         in_wr = 1'b1;
         @(posedge clk); #1;
      end
      chk("pre_rst_wr", 64'(out_wr), 64'h2);
      in_data = 64'h1111; in_ctrl = 8'h00;
      #2 reset = 1'b0;
      #1;
      chk("arst_req", 64'(out_req), 64'd0);
      chk("arst_wr", 64'(out_wr), 64'd0);
      chk("arst_rdy", 64'(in_rdy), 64'd0);
      chk("arst_route", 64'(out_pkt_route[24 +: 24]), 64'd0);
      chk("arst_proto", 64'(out_protocol), 64'd0);
      chk("arst_cur", 64'(cur_output), 64'd0);
      in_wr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      id++;
      send_pkt(0, 6, 8'h00, id); id++;

      // empty mask holds off requests, then a single enabled output repeats
      core_enable = '0;
      repeat (3) @(posedge clk); #1;
      rq = '0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         rq = rq | out_req;
      end
      chk("empty_mask_req", 64'(rq), 64'd0);
      core_enable = 4'b0100;
      send_pkt(2, 6, 8'h00, id); id++;
      send_pkt(2, 6, 8'h00, id); id++;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
